// File: rtl/minbd_side_buffer.sv
// Deflection-router side buffer: FIFO of deflected flits with a head starvation timer/redirect request.
// Optional push/redirect statistics counters are compiled in when SIDEBUF_STATS_EN is defined.
module minbd_side_buffer #(
    parameter int FLIT_W     = 64,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
`ifdef SIDEBUF_STATS_EN
    output logic [15:0]       stat_push,
    output logic [15:0]       stat_redirect,
`endif
    output logic              redirect_req
);

    // Handshakes: a push happens when in_valid & in_ready, a pop when out_valid & out_ready,
    // both evaluated at the same rising edge; neither side may assume the other waits.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = $clog2(STARVE_LIM + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        STARVED = 1'b1
    } starve_state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    starve_state_t     state;
    starve_state_t     state_nxt;
    logic              push;
    logic              pop;

    assign out_valid    = (count != '0);
    assign in_ready     = (count < CNT_W'(DEPTH)) | out_ready;
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign out_flit     = out_valid ? mem[rd_ptr] : '0;
    assign redirect_req = (state == STARVED);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Timer counts cycles the head is offered but not taken, saturating at the limit.
    always_comb begin
        timer_nxt = timer;
        if (!out_valid || pop) begin
            timer_nxt = '0;
        end else if (timer < TMR_W'(STARVE_LIM)) begin
            timer_nxt = timer + TMR_W'(1);
        end
    end

    // STARVED is entered on the same edge the timer reaches the limit, so redirect_req
    // rises in the cycle right after the head has waited STARVE_LIM cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (out_valid && !pop && timer_nxt == TMR_W'(STARVE_LIM)) begin
                    state_nxt = STARVED;
                end
            end
            STARVED: begin
                if (pop || !out_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            timer  <= '0;
            state  <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            timer <= timer_nxt;
            state <= state_nxt;
        end
    end

    // Storage is not reset; out_flit is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

`ifdef SIDEBUF_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_push     <= '0;
            stat_redirect <= '0;
        end else begin
            if (push && stat_push != 16'hFFFF) begin
                stat_push <= stat_push + 16'd1;
            end
            if (state == IDLE && state_nxt == STARVED && stat_redirect != 16'hFFFF) begin
                stat_redirect <= stat_redirect + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_minbd_side_buffer.sv
// Testbench for minbd_side_buffer: directed scenarios plus randomized traffic checked by a
// queue-based reference model; define SIDEBUF_STATS_EN to also check the statistics outputs.
module tb_minbd_side_buffer;

    localparam int FLIT_W = 64;
    localparam int DEPTH  = 4;
    localparam int LIM    = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_ready;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              redirect_req;
`ifdef SIDEBUF_STATS_EN
    logic [15:0]       stat_push;
    logic [15:0]       stat_redirect;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [FLIT_W-1:0] exp_q[$];
    int                starve_cycles = 0;
    int                m_push  = 0;
    int                m_redir = 0;
    bit                chk_en  = 1'b0;
    bit                m_pop_ev;
    bit                m_push_ev;

    minbd_side_buffer #(
        .FLIT_W(FLIT_W),
        .DEPTH(DEPTH),
        .STARVE_LIM(LIM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_flit(in_flit),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_flit(out_flit),
        .out_ready(out_ready),
        .count(count),
`ifdef SIDEBUF_STATS_EN
        .stat_push(stat_push),
        .stat_redirect(stat_redirect),
`endif
        .redirect_req(redirect_req)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the buffer is a plain queue; the head's starvation is the number of consecutive
    // cycles it was offered and refused.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            starve_cycles = 0;
            m_push  = 0;
            m_redir = 0;
            chk_en  = 1'b1;
        end else if (chk_en) begin
            m_pop_ev  = (exp_q.size() != 0) && out_ready;
            m_push_ev = in_valid && ((exp_q.size() < DEPTH) || out_ready);
            if (exp_q.size() == 0 || m_pop_ev) begin
                starve_cycles = 0;
            end else begin
                starve_cycles++;
                if (starve_cycles == LIM && m_redir < 65535) m_redir++;
            end
            if (m_pop_ev) void'(exp_q.pop_front());
            if (m_push_ev) begin
                exp_q.push_back(in_flit);
                if (m_push < 65535) m_push++;
            end
        end
    end

    // Monitor: compares everything the DUT presents, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", FLIT_W'(out_valid), FLIT_W'(exp_q.size() != 0));
            check("count", FLIT_W'(count), FLIT_W'(exp_q.size()));
            check("out_flit", out_flit, (exp_q.size() != 0) ? exp_q[0] : '0);
            check("in_ready", FLIT_W'(in_ready), FLIT_W'((exp_q.size() < DEPTH) || out_ready));
            check("redirect_req", FLIT_W'(redirect_req), FLIT_W'(starve_cycles >= LIM));
`ifdef SIDEBUF_STATS_EN
            check("stat_push", FLIT_W'(stat_push), FLIT_W'(m_push));
            check("stat_redirect", FLIT_W'(stat_redirect), FLIT_W'(m_redir));
`endif
        end
    end

    // Driver tasks: inputs change 1 time unit after the edge and apply at the next edge.
    task automatic drive(input logic iv, input logic [FLIT_W-1:0] f, input logic ordy);
        in_valid  = iv;
        in_flit   = f;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_flit   = {$urandom, $urandom};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [FLIT_W-1:0] flits [5];
    logic [FLIT_W-1:0] fa;
    bit                stall;
    int                stall_left;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset then idle
        repeat (5) drive(1'b0, '0, 1'b0);
        check("t1_out_valid", FLIT_W'(out_valid), '0);
        check("t1_count", FLIT_W'(count), '0);
        check("t1_in_ready", FLIT_W'(in_ready), FLIT_W'(1));
        check("t1_redirect", FLIT_W'(redirect_req), '0);

        // Single push then pop
        fa = 64'hA5A5_A5A5_A5A5_A5A5;
        drive(1'b1, fa, 1'b0);
        check("t2_out_valid", FLIT_W'(out_valid), FLIT_W'(1));
        check("t2_out_flit", out_flit, fa);
        check("t2_count", FLIT_W'(count), FLIT_W'(1));
        drive(1'b0, '0, 1'b1);
        check("t2_count_after_pop", FLIT_W'(count), '0);
        check("t2_valid_after_pop", FLIT_W'(out_valid), '0);

        // Fill, push into full with simultaneous pop, drain in order
        for (int i = 0; i < 5; i++) flits[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) drive(1'b1, flits[i], 1'b0);
        check("t3_count_full", FLIT_W'(count), FLIT_W'(DEPTH));
        check("t3_in_ready_full", FLIT_W'(in_ready), '0);
        drive(1'b1, flits[4], 1'b1);
        check("t3_count_push_pop", FLIT_W'(count), FLIT_W'(DEPTH));
        for (int i = 1; i < 5; i++) begin
            check("t3_order", out_flit, flits[i]);
            drive(1'b0, '0, 1'b1);
        end
        check("t3_drained", FLIT_W'(count), '0);

        // Starvation of a held head
        do_reset();
        drive(1'b1, fa, 1'b0);
        repeat (LIM - 1) drive(1'b0, '0, 1'b0);
        check("t4_no_redirect_yet", FLIT_W'(redirect_req), '0);
        drive(1'b0, '0, 1'b0);
        check("t4_redirect", FLIT_W'(redirect_req), FLIT_W'(1));
`ifdef SIDEBUF_STATS_EN
        check("t6_stat_push", FLIT_W'(stat_push), FLIT_W'(1));
        check("t6_stat_redirect", FLIT_W'(stat_redirect), FLIT_W'(1));
`endif
        drive(1'b0, '0, 1'b0);
        check("t4_redirect_held", FLIT_W'(redirect_req), FLIT_W'(1));
        drive(1'b0, '0, 1'b1);
        check("t4_redirect_clear", FLIT_W'(redirect_req), '0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) drive(1'b1, {$urandom, $urandom}, 1'b0);
        check("t5_count3", FLIT_W'(count), FLIT_W'(3));
        do_reset();
        check("t5_count", FLIT_W'(count), '0);
        check("t5_out_valid", FLIT_W'(out_valid), '0);
        check("t5_redirect", FLIT_W'(redirect_req), '0);

        // Randomized traffic with periodic stall bursts and rare resets
        stall = 1'b0;
        stall_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!stall && $urandom_range(0, 60) == 0) begin
                stall = 1'b1;
                stall_left = $urandom_range(3, 14);
            end
            if (stall) begin
                stall_left--;
                if (stall_left <= 0) stall = 1'b0;
            end
            if ($urandom_range(0, 700) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 2) != 0, {$urandom, $urandom},
                      stall ? 1'b0 : ($urandom_range(0, 3) != 0));
            end
        end
        repeat (6) drive(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
